// File: rtl/booth_seq_multiplier.sv
// Iterative radix-2 Booth multiplier with a start/done handshake.
// One Booth step per clock; signed WIDTH x WIDTH operands give a signed 2*WIDTH product.
module booth_seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   m;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [CW-1:0]    count;

    // Booth add/subtract selected by the current multiplier bit and the history bit
    always_comb begin
        sum = acc;
        case ({q[0], q_1})
            2'b10:   sum = acc - m;
            2'b01:   sum = acc + m;
            default: sum = acc;
        endcase
    end

    // Sequencer: accept, iterate WIDTH Booth steps, then pulse done for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            m           <= '0;
            q           <= '0;
            q_1         <= 1'b0;
            count       <= '0;
            product     <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        q           <= a;
                        m           <= {b[WIDTH-1], b};
                        acc         <= '0;
                        q_1         <= 1'b0;
                        count       <= CW'(WIDTH);
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    // Arithmetic right shift of {sum, q, q_1}; the product after the
                    // final step is read straight from the pre-shift sum and q.
                    acc   <= {sum[WIDTH], sum[WIDTH:1]};
                    q     <= {sum[0], q[WIDTH-1:1]};
                    q_1   <= q[0];
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        product <= {sum, q[WIDTH-1:1]};
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Bench for booth_seq_multiplier: transaction-level reference model plus literal pins.
module tb_booth_seq_multiplier;

    localparam int W  = 4;
    localparam int W2 = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [W2-1:0] product;
    logic          done;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    booth_seq_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .product     (product),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: an op occupies W+1 cycles after acceptance; result = a*b.
    int            m_left    = 0;
    logic [W2-1:0] m_pend    = '0;
    logic [W2-1:0] m_product = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left    = 0;
            m_product = '0;
        end else if (m_left == 0) begin
            if (start_valid) begin
                m_left = W + 1;
                m_pend = W2'(int'($signed(a)) * int'($signed(b)));
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 1) m_product = m_pend;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        chk("start_ready", 32'(start_ready), 32'(m_left == 0));
        chk("busy",        32'(busy),        32'(m_left != 0));
        chk("done",        32'(done),        32'(m_left == 1));
        chk("product",     32'(product),     32'(m_product));
    end

    task automatic do_op(input int ia, input int ib, output logic [W2-1:0] p, output int lat);
        int k;
        @(negedge clk);
        k = 0;
        while (!start_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("ready_timeout", 32'(start_ready), 32'd1);
        a = W'(ia);
        b = W'(ib);
        start_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            start_valid = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            lat++;
        end while (!done && lat < 50);
        start_valid = 1'b0;
        chk("done_timeout", 32'(done), 32'd1);
        p = product;
    endtask

    int            ta[6] = '{3, -3, 5, 0, -8, -8};
    int            tb[6] = '{5, 5, -3, -8, -8, 7};
    logic [7:0]    tp[6] = '{8'h0F, 8'hF1, 8'hF1, 8'h00, 8'h40, 8'hC8};
    int            ba[3] = '{2, -1, 7};
    int            bb[3] = '{3, -1, -8};
    logic [7:0]    bp[3] = '{8'h06, 8'h01, 8'hC8};

    initial begin
        logic [W2-1:0] p;
        int            lat;
        int            k;
        int            nd;
        int            acc_cyc[3];
        logic [W2-1:0] res[$];

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready",   32'(start_ready), 32'd1);
        chk("reset_busy",    32'(busy),        32'd0);
        chk("reset_done",    32'(done),        32'd0);
        chk("reset_product", 32'(product),     32'd0);

        // Hand-computed products pin both the DUT and the model
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], p, lat);
            chk("lit_product", 32'(p),         32'(tp[i]));
            chk("lit_model",   32'(m_product), 32'(tp[i]));
            chk("lit_latency", 32'(lat),       32'(W + 1));
        end

        // Back-to-back with start_valid held high and operands scrambled while busy
        k = 0;
        @(negedge clk);
        start_valid = 1'b1;
        for (int c = 0; c < 60 && res.size() < 3; c++) begin
            if (done) res.push_back(product);
            if (start_ready && k < 3) begin
                a = W'(ba[k]);
                b = W'(bb[k]);
                acc_cyc[k] = c;
                k++;
            end else begin
                a = W'($urandom);
                b = W'($urandom);
                if (k == 3) start_valid = 1'b0;
            end
            @(negedge clk);
        end
        start_valid = 1'b0;
        chk("b2b_count", 32'(res.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("b2b_result", (i < res.size()) ? 32'(res[i]) : 'x, 32'(bp[i]));
        chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
        chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(W + 2));

        // Asynchronous reset in the second CALC cycle aborts the op
        @(negedge clk);
        while (!start_ready) @(negedge clk);
        a = W'(3);
        b = W'(5);
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready",   32'(start_ready), 32'd1);
        chk("arst_busy",    32'(busy),        32'd0);
        chk("arst_done",    32'(done),        32'd0);
        chk("arst_product", 32'(product),     32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 2 * W + 4; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("arst_no_done", 32'(nd), 32'd0);
        do_op(-7, 6, p, lat);
        chk("arst_recover", 32'(p), 32'hD6);

        // Exhaustive operand sweep; the compare process checks every cycle
        for (int ia = -(1 << (W - 1)); ia < (1 << (W - 1)); ia++)
            for (int ib = -(1 << (W - 1)); ib < (1 << (W - 1)); ib++) begin
                do_op(ia, ib, p, lat);
                chk("sweep_latency", 32'(lat), 32'(W + 1));
            end

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
